// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes single-byte commands (optional argument byte), holds the
// Sobel control registers, counts camera frames and sequences multi-byte responses onto UART TX.
module uart_cmd_ctrl #(
    parameter int unsigned CLK_FREQ         = 27_000_000,
    parameter int unsigned ARG_TIMEOUT_CYC  = CLK_FREQ / 10,
    parameter logic [7:0]  THRESH_DEFAULT   = 8'd64,
    parameter logic        SOBEL_EN_DEFAULT = 1'b0
) (
    input  logic        sys_clk,
    input  logic        sys_resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        cam_vsync,
    output logic        sobel_enable,
    output logic [7:0]  sobel_threshold,
    output logic [15:0] frame_count,
    output logic        cmd_busy,
    output logic        err_flag
);

    localparam int unsigned     TO_W    = $clog2(ARG_TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ARG_TIMEOUT_CYC - 1);

    localparam logic [7:0] CMD_EN     = 8'h53;
    localparam logic [7:0] CMD_DIS    = 8'h73;
    localparam logic [7:0] CMD_THRESH = 8'h54;
    localparam logic [7:0] CMD_READ   = 8'h52;
    localparam logic [7:0] CMD_DUMP   = 8'h44;
    localparam logic [7:0] RESP_OK    = 8'h4B;
    localparam logic [7:0] RESP_ERR   = 8'h45;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ARG,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      resp_b1_q, resp_b1_d;
    logic            resp_more_q, resp_more_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            sobel_en_q, sobel_en_d;
    logic [7:0]      thresh_q, thresh_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic            vs_meta_q, vs_sync_q, vs_prev_q;
    logic [15:0]     frame_cnt_q;
    logic            vs_rise;

    // Frame counter: 2-FF synchronizer, then rising-edge detect on the synchronized level.
    assign vs_rise = vs_sync_q & ~vs_prev_q;

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            vs_meta_q   <= 1'b0;
            vs_sync_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            vs_meta_q <= cam_vsync;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
            if (vs_rise) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q     <= IDLE;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            resp_b1_q   <= '0;
            resp_more_q <= 1'b0;
            to_cnt_q    <= '0;
            sobel_en_q  <= SOBEL_EN_DEFAULT;
            thresh_q    <= THRESH_DEFAULT;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            resp_b1_q   <= resp_b1_d;
            resp_more_q <= resp_more_d;
            to_cnt_q    <= to_cnt_d;
            sobel_en_q  <= sobel_en_d;
            thresh_q    <= thresh_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        resp_b1_d   = resp_b1_q;
        resp_more_d = resp_more_q;
        to_cnt_d    = to_cnt_q;
        sobel_en_d  = sobel_en_q;
        thresh_d    = thresh_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    state_d     = RESP;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = RESP_OK;
                    resp_more_d = 1'b0;
                    case (rx_data)
                        CMD_EN:  sobel_en_d = 1'b1;
                        CMD_DIS: sobel_en_d = 1'b0;
                        CMD_THRESH: begin
                            state_d    = WAIT_ARG;
                            tx_valid_d = 1'b0;
                            to_cnt_d   = '0;
                        end
                        // The snapshot is the registered count, so a same-cycle increment is excluded.
                        CMD_READ: begin
                            tx_data_d   = frame_cnt_q[15:8];
                            resp_b1_d   = frame_cnt_q[7:0];
                            resp_more_d = 1'b1;
                        end
                        CMD_DUMP: begin
                            tx_data_d   = thresh_q;
                            resp_b1_d   = {sobel_en_q, err_q, 6'b0};
                            resp_more_d = 1'b1;
                            err_d       = 1'b0;
                        end
                        default: begin
                            tx_data_d = RESP_ERR;
                            err_d     = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_ARG: begin
                if (rx_valid) begin
                    thresh_d    = rx_data;
                    state_d     = RESP;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = RESP_OK;
                    resp_more_d = 1'b0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = RESP;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = RESP_ERR;
                    resp_more_d = 1'b0;
                    err_d       = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            RESP: begin
                if (rx_valid) begin
                    err_d = 1'b1;
                end
                if (tx_valid_q && tx_ready) begin
                    if (resp_more_q) begin
                        tx_data_d   = resp_b1_q;
                        resp_more_d = 1'b0;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign tx_data         = tx_data_q;
    assign tx_valid        = tx_valid_q;
    assign sobel_enable    = sobel_en_q;
    assign sobel_threshold = thresh_q;
    assign frame_count     = frame_cnt_q;
    assign cmd_busy        = busy_q;
    assign err_flag        = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed + randomized bench for uart_cmd_ctrl against a command-level reference model.
module tb_uart_cmd_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cam_vsync;
    logic        sobel_enable;
    logic [7:0]  sobel_threshold;
    logic [15:0] frame_count;
    logic        cmd_busy;
    logic        err_flag;

    uart_cmd_ctrl #(.ARG_TIMEOUT_CYC(TIMEOUT)) dut (
        .sys_clk(clk), .sys_resetn(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cam_vsync(cam_vsync),
        .sobel_enable(sobel_enable), .sobel_threshold(sobel_threshold),
        .frame_count(frame_count), .cmd_busy(cmd_busy), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic        m_en;
    logic [7:0]  m_th;
    logic        m_err;
    logic [15:0] m_fc;
    logic [7:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_en = 1'b0; m_th = 8'd64; m_err = 1'b0; m_fc = 16'd0;
        exp_q.delete();
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".en"},  sobel_enable, m_en);
        check({tag, ".th"},  sobel_threshold, m_th);
        check({tag, ".err"}, err_flag, m_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".txv"},  tx_valid, 0);
        check({tag, ".txd"},  tx_data, 0);
        check({tag, ".busy"}, cmd_busy, 0);
        check({tag, ".fc"},   frame_count, 0);
        check_regs(tag);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_vsync(input int n);
        for (int i = 0; i < n; i++) begin
            cam_vsync = 1'b1; tick(); tick();
            cam_vsync = 1'b0; tick(); tick();
        end
        m_fc = m_fc + 16'(n);
        check("frame_count", frame_count, m_fc);
    endtask

    // Pops expected bytes as they are accepted; tx_data is compared every valid cycle,
    // which also covers stability under back-pressure.
    task automatic drain(input bit rand_ready);
        int  cyc = 0;
        logic acc;
        while (exp_q.size() > 0 && cyc < 400) begin
            if (tx_valid) check("tx_data", tx_data, exp_q[0]);
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = tx_valid && tx_ready;
            tick(); cyc++;
            if (acc) void'(exp_q.pop_front());
        end
        tx_ready = 1'b0;
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
        check("idle_txv", tx_valid, 0);
        check("idle_busy", cmd_busy, 0);
    endtask

    // Applies a single-byte command in IDLE and records the expected response.
    task automatic issue(input logic [7:0] c);
        case (c)
            8'h53: begin m_en = 1'b1; exp_q.push_back(8'h4B); end
            8'h73: begin m_en = 1'b0; exp_q.push_back(8'h4B); end
            8'h52: begin exp_q.push_back(m_fc[15:8]); exp_q.push_back(m_fc[7:0]); end
            8'h44: begin
                exp_q.push_back(m_th);
                exp_q.push_back({m_en, m_err, 6'b0});
                m_err = 1'b0;
            end
            default: begin exp_q.push_back(8'h45); m_err = 1'b1; end
        endcase
        send_byte(c);
        check("cmd_txv", tx_valid, 1);
        check("cmd_busy", cmd_busy, 1);
        check("cmd_txd", tx_data, exp_q[0]);
        check_regs("cmd");
    endtask

    task automatic thresh_cmd(input bit timeout, input int dly, input logic [7:0] arg, input bit rand_ready);
        send_byte(8'h54);
        check("T_busy", cmd_busy, 1);
        if (timeout) begin
            for (int i = 0; i < TIMEOUT; i++) begin
                check("T_wait_txv", tx_valid, 0);
                tick();
            end
            m_err = 1'b1;
            exp_q.push_back(8'h45);
        end else begin
            for (int i = 0; i < dly; i++) tick();
            check("T_arg_txv", tx_valid, 0);
            send_byte(arg);
            m_th = arg;
            exp_q.push_back(8'h4B);
        end
        check("T_txv", tx_valid, 1);
        check_regs("T");
        drain(rand_ready);
    endtask

    function automatic logic [7:0] rand_bad();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == 8'h53 || b == 8'h73 || b == 8'h54 || b == 8'h52 || b == 8'h44);
        return b;
    endfunction

    initial begin
        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0; cam_vsync = 1'b0;
        model_reset();
        tick(); tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 'S' with tx_ready already high: one-cycle response
        tx_ready = 1'b1;
        issue(8'h53);
        drain(1'b0);
        check_regs("after_S");

        // 'T' then argument ten cycles later, then 'D'
        thresh_cmd(1'b0, 10, 8'hA5, 1'b0);
        issue(8'h44);
        drain(1'b1);

        // Timeout, then 'D' reports and clears the error
        issue(8'h73);
        drain(1'b0);
        thresh_cmd(1'b1, 0, 8'h00, 1'b0);
        issue(8'h44);
        drain(1'b0);
        check_regs("after_D_clear");

        // 258 frames from reset, 'R' under back-pressure with vsync activity
        rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1; tick();
        pulse_vsync(258);
        issue(8'h52);
        for (int i = 0; i < 20; i++) begin
            cam_vsync = ((i / 2) % 2) == 0;
            check("R_hold_txv", tx_valid, 1);
            check("R_hold_txd", tx_data, 8'h01);
            tick();
        end
        cam_vsync = 1'b0;
        drain(1'b0);
        tick(); tick();
        m_fc = m_fc + 16'd5;
        check("fc_after_R", frame_count, m_fc);

        // Vsync increment landing in the same cycle as the 'R' snapshot
        cam_vsync = 1'b1; tick(); tick();
        issue(8'h52);
        cam_vsync = 1'b0;
        m_fc = m_fc + 16'd1;
        drain(1'b1);
        check("fc_same_cycle", frame_count, m_fc);

        // Wrap from 0xFFFF
        tick();
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        m_fc = 16'hFFFF;
        check("fc_forced", frame_count, 16'hFFFF);
        pulse_vsync(1);
        issue(8'h52);
        drain(1'b0);

        // Unknown command
        issue(8'h58);
        drain(1'b0);

        // RX while responding is dropped
        issue(8'h44);
        send_byte(8'h53);
        m_err = 1'b1;
        check_regs("drop_mid");
        drain(1'b1);
        issue(8'h73);
        tx_ready = 1'b1; rx_data = 8'h53; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0; tx_ready = 1'b0; void'(exp_q.pop_front());
        m_err = 1'b1;
        check("drop_last_txv", tx_valid, 0);
        check("drop_last_busy", cmd_busy, 0);
        check_regs("drop_last");

        // Randomized command stream
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: issue(8'h53);
                1: issue(8'h73);
                2: issue(8'h52);
                3: issue(8'h44);
                4: issue(rand_bad());
                5: thresh_cmd(1'b0, $urandom_range(0, TIMEOUT - 2), 8'($urandom_range(0, 255)), 1'b1);
                default: begin
                    pulse_vsync($urandom_range(1, 12));
                    continue;
                end
            endcase
            if (exp_q.size() > 0) drain(1'b1);
        end
        if ($urandom_range(0, 1) == 1) thresh_cmd(1'b1, 0, 8'h00, 1'b1);

        // Asynchronous reset in the middle of an 'R' response
        issue(8'h52);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
